// File: rtl/mac_stream_array.sv
// mac_stream_array: multi-lane streaming signed dot-product engine.
// A command sets the length, lane mask and accumulate mode. Operand beats are then
// multiply-accumulated per lane, and the clamped results are returned on a
// valid/ready port together with per-lane saturation flags.
module mac_stream_array #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned RES_WIDTH  = 16,
    parameter int unsigned MAX_LENGTH = 64,
    parameter int unsigned NUM_UNITS  = 64,
    localparam int unsigned LEN_W     = $clog2(MAX_LENGTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [LEN_W-1:0]                     cmd_length,
    input  logic [NUM_UNITS-1:0]                 cmd_lane_mask,
    input  logic                                 cmd_accumulate,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_UNITS-1:0][WIDTH-1:0]      a_in_array,
    input  logic [NUM_UNITS-1:0][WIDTH-1:0]      b_in_array,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [NUM_UNITS-1:0][RES_WIDTH-1:0]  result_array,
    output logic [NUM_UNITS-1:0]                 res_lane_mask,
    output logic [NUM_UNITS-1:0]                 sat_array,
    output logic                                 busy
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned MSB    = ACC_WIDTH - 1;

    // Clamp bounds of the result range, expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
        {{(ACC_WIDTH - RES_WIDTH + 1){1'b0}}, {(RES_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] RES_MIN =
        {{(ACC_WIDTH - RES_WIDTH + 1){1'b1}}, {(RES_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_RESULT
    } state_t;

    state_t                        state;
    logic [LEN_W-1:0]              length;
    logic [LEN_W-1:0]              count;
    logic [NUM_UNITS-1:0]          lane_mask;
    logic signed [ACC_WIDTH-1:0]   acc      [NUM_UNITS];
    logic [NUM_UNITS-1:0]          ovf;

    logic signed [PROD_W-1:0]      prod     [NUM_UNITS];
    logic signed [ACC_WIDTH-1:0]   prod_ext [NUM_UNITS];
    logic signed [ACC_WIDTH-1:0]   sum      [NUM_UNITS];
    logic signed [ACC_WIDTH-1:0]   acc_nxt  [NUM_UNITS];
    logic [NUM_UNITS-1:0]          wrap;
    logic [NUM_UNITS-1:0]          ovf_nxt;
    logic [NUM_UNITS-1:0]          mask_eff;
    logic [NUM_UNITS-1:0][RES_WIDTH-1:0] res_c;
    logic [NUM_UNITS-1:0]          sat_c;
    logic [NUM_UNITS-1:0]          hi_c;
    logic [NUM_UNITS-1:0]          lo_c;

    logic                          cmd_fire;
    logic                          beat_fire;
    logic                          last_beat;
    logic [LEN_W-1:0]              len_clamped;

    // Handshake decode and length clamping.
    always_comb begin
        cmd_fire    = cmd_valid && cmd_ready;
        beat_fire   = in_valid && in_ready;
        len_clamped = (cmd_length > LEN_W'(MAX_LENGTH)) ? LEN_W'(MAX_LENGTH) : cmd_length;
        last_beat   = beat_fire && (count == (length - LEN_W'(1)));
        // A zero-length command produces its result from the mask being accepted now.
        mask_eff    = cmd_fire ? cmd_lane_mask : lane_mask;
    end

    // Per-lane MAC update, wrap detection and result clamping.
    always_comb begin
        wrap    = '0;
        ovf_nxt = ovf;
        res_c   = '0;
        sat_c   = '0;
        hi_c    = '0;
        lo_c    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            prod[i]     = PROD_W'($signed(a_in_array[i])) * PROD_W'($signed(b_in_array[i]));
            prod_ext[i] = ACC_WIDTH'(prod[i]);
            sum[i]      = acc[i] + prod_ext[i];
            wrap[i]     = (acc[i][MSB] == prod_ext[i][MSB]) && (sum[i][MSB] != acc[i][MSB]);
            acc_nxt[i]  = acc[i];
            if (cmd_fire && !cmd_accumulate) begin
                acc_nxt[i] = '0;
                ovf_nxt[i] = 1'b0;
            end else if (beat_fire && lane_mask[i]) begin
                acc_nxt[i] = sum[i];
                ovf_nxt[i] = ovf[i] | wrap[i];
            end
            hi_c[i] = acc_nxt[i] > RES_MAX;
            lo_c[i] = acc_nxt[i] < RES_MIN;
            if (hi_c[i]) begin
                res_c[i] = RES_MAX[RES_WIDTH-1:0];
            end else if (lo_c[i]) begin
                res_c[i] = RES_MIN[RES_WIDTH-1:0];
            end else begin
                res_c[i] = acc_nxt[i][RES_WIDTH-1:0];
            end
            sat_c[i] = hi_c[i] | lo_c[i] | ovf_nxt[i];
            if (!mask_eff[i]) begin
                res_c[i] = '0;
                sat_c[i] = 1'b0;
            end
        end
    end

    // Control FSM, accumulators and registered result port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            length        <= '0;
            count         <= '0;
            lane_mask     <= '0;
            ovf           <= '0;
            cmd_ready     <= 1'b1;
            in_ready      <= 1'b0;
            res_valid     <= 1'b0;
            busy          <= 1'b0;
            result_array  <= '0;
            sat_array     <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                acc[i] <= acc_nxt[i];
            end
            ovf <= ovf_nxt;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        length    <= len_clamped;
                        lane_mask <= cmd_lane_mask;
                        count     <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (len_clamped == '0) begin
                            state        <= S_RESULT;
                            res_valid    <= 1'b1;
                            result_array <= res_c;
                            sat_array    <= sat_c;
                        end else begin
                            state    <= S_STREAM;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (beat_fire) begin
                        count <= count + LEN_W'(1);
                        if (last_beat) begin
                            state        <= S_RESULT;
                            in_ready     <= 1'b0;
                            res_valid    <= 1'b1;
                            result_array <= res_c;
                            sat_array    <= sat_c;
                        end
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign res_lane_mask = lane_mask;

endmodule
